// File: rtl/cntr_checker.sv
// -----------------------------------------------------------------------------
// cntr_checker
//
// Receive-side companion to the configurable modulo counter. It watches a
// stream of counter samples and locks onto the sequence
// (prev +/- STEP) mod CNT_MODULE. Once locked, every deviation produces a
// one-cycle err pulse and bumps a saturating error counter.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      asynchronous active-low reset
//   cnt_in     in   W      sampled counter value
//   cnt_vld    in   1      cnt_in valid; nothing is sampled otherwise
//   clr        in   1      synchronous clear of err_cnt
//   locked     out  1      checker is locked to the sequence
//   err        out  1      one-cycle pulse: mismatch seen while locked
//   err_range  out  1      with err: offending sample was >= CNT_MODULE
//   err_cnt    out  ERR_W  saturating count of err pulses
//   expected   out  W      next value expected (valid while locked)
// -----------------------------------------------------------------------------
module cntr_checker #(
  parameter int STEP       = 1,
  parameter int CNT_MODULE = 16,
  parameter int REVERSE    = 0,
  parameter int LOCK_CNT   = 4,
  parameter int ERR_W      = 16,
  localparam int W         = $clog2(CNT_MODULE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [W-1:0]     cnt_in,
  input  logic             cnt_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic             err_range,
  output logic [ERR_W-1:0] err_cnt,
  output logic [W-1:0]     expected
);

  localparam int STEP_M = STEP % CNT_MODULE;
  localparam int MC_W   = $clog2(LOCK_CNT + 1);

  // One extra bit so p + STEP_M and p + CNT_MODULE never overflow.
  localparam logic [W:0] MOD_X  = (W+1)'(CNT_MODULE);
  localparam logic [W:0] STEP_X = (W+1)'(STEP_M);

  localparam logic [MC_W-1:0]  LOCK_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [W-1:0]     expected_q, expected_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic             err_q, err_d;
  logic             err_range_q, err_range_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_range;
  logic             is_match;

  // Successor of p in the expected sequence, wrapped into 0..CNT_MODULE-1.
  function automatic logic [W-1:0] nxt(input logic [W-1:0] p);
    logic [W:0] px;
    logic [W:0] res;
    px = {1'b0, p};
    if (REVERSE == 0) begin
      res = px + STEP_X;
      if (res >= MOD_X) begin
        res = res - MOD_X;
      end
    end else begin
      if (px >= STEP_X) begin
        res = px - STEP_X;
      end else begin
        res = px + MOD_X - STEP_X;
      end
    end
    return res[W-1:0];
  endfunction

  assign in_range = ({1'b0, cnt_in} < MOD_X);
  // Out-of-range samples never match, even if their low bits happen to.
  assign is_match = in_range && (cnt_in == nxt(prev_q));

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    err_range_d = 1'b0;

    if (cnt_vld) begin
      // Every state takes an in-range sample as the new reference point.
      if (in_range) begin
        prev_d     = cnt_in;
        expected_d = nxt(cnt_in);
      end

      case (state_q)
        IDLE: begin
          if (in_range) begin
            match_cnt_d = '0;
            state_d     = ACQ;
          end
        end

        ACQ: begin
          if (is_match) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q == LOCK_LAST) begin
              state_d = LOCK;
            end
          end else if (in_range) begin
            match_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end

        LOCK: begin
          if (!is_match) begin
            err_d       = 1'b1;
            err_range_d = !in_range;
            match_cnt_d = '0;
            state_d     = in_range ? ACQ : IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // clr wins over accumulation but a coincident error still counts once.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = err_d ? ERR_W'(1) : '0;
    end else if (err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      expected_q  <= '0;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
      err_range_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      err_range_q <= err_range_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == LOCK);
  assign err       = err_q;
  assign err_range = err_range_q;
  assign err_cnt   = err_cnt_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_cntr_checker.sv
// -----------------------------------------------------------------------------
// tb_cntr_checker
//
// Four checker instances with different parameter sets share one clock and
// reset. Each transaction pushes its hand-derived expected outputs onto a
// scoreboard queue; after the sampling edge the entry is popped and compared
// with the selected instance's outputs.
//   inst 0: fwd  M=17 STEP=3 LOCK_CNT=4 ERR_W=16
//   inst 1: rev  M=17 STEP=3 LOCK_CNT=4 ERR_W=16
//   inst 2: rev  M=8  STEP=5 LOCK_CNT=4 ERR_W=16
//   inst 3: fwd  M=16 STEP=1 LOCK_CNT=1 ERR_W=2  (saturation)
// -----------------------------------------------------------------------------
module tb_cntr_checker;

  logic        CLK;
  logic        RST;
  logic [4:0]  cin [4];
  logic        vld [4];
  logic        clr [4];
  logic        lk  [4];
  logic        er  [4];
  logic        rg  [4];
  logic [15:0] ec_a, ec_b, ec_c;
  logic [1:0]  ec_d;
  logic [4:0]  ex_a, ex_b;
  logic [2:0]  ex_c;
  logic [3:0]  ex_d;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    lk;
    int    er;
    int    rg;
    int    ec;
    int    ex;
  } exp_t;

  exp_t sb[$];

  cntr_checker #(.STEP(3), .CNT_MODULE(17), .REVERSE(0), .LOCK_CNT(4), .ERR_W(16)) u_a (
    .CLK(CLK), .RST(RST), .cnt_in(cin[0]), .cnt_vld(vld[0]), .clr(clr[0]),
    .locked(lk[0]), .err(er[0]), .err_range(rg[0]), .err_cnt(ec_a), .expected(ex_a)
  );

  cntr_checker #(.STEP(3), .CNT_MODULE(17), .REVERSE(1), .LOCK_CNT(4), .ERR_W(16)) u_b (
    .CLK(CLK), .RST(RST), .cnt_in(cin[1]), .cnt_vld(vld[1]), .clr(clr[1]),
    .locked(lk[1]), .err(er[1]), .err_range(rg[1]), .err_cnt(ec_b), .expected(ex_b)
  );

  cntr_checker #(.STEP(5), .CNT_MODULE(8), .REVERSE(1), .LOCK_CNT(4), .ERR_W(16)) u_c (
    .CLK(CLK), .RST(RST), .cnt_in(cin[2][2:0]), .cnt_vld(vld[2]), .clr(clr[2]),
    .locked(lk[2]), .err(er[2]), .err_range(rg[2]), .err_cnt(ec_c), .expected(ex_c)
  );

  cntr_checker #(.STEP(1), .CNT_MODULE(16), .REVERSE(0), .LOCK_CNT(1), .ERR_W(2)) u_d (
    .CLK(CLK), .RST(RST), .cnt_in(cin[3][3:0]), .cnt_vld(vld[3]), .clr(clr[3]),
    .locked(lk[3]), .err(er[3]), .err_range(rg[3]), .err_cnt(ec_d), .expected(ex_d)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int inst, output int o_lk, output int o_er,
                        output int o_rg, output int o_ec, output int o_ex);
    o_lk = int'(lk[inst]);
    o_er = int'(er[inst]);
    o_rg = int'(rg[inst]);
    case (inst)
      0:       begin o_ec = int'(ec_a); o_ex = int'(ex_a); end
      1:       begin o_ec = int'(ec_b); o_ex = int'(ex_b); end
      2:       begin o_ec = int'(ec_c); o_ex = int'(ex_c); end
      default: begin o_ec = int'(ec_d); o_ex = int'(ex_d); end
    endcase
  endtask

  task automatic compare(input int inst, input exp_t e);
    int o_lk, o_er, o_rg, o_ec, o_ex;
    sample(inst, o_lk, o_er, o_rg, o_ec, o_ex);
    $display("inst%0d %-12s locked=%0d err=%0d err_range=%0d err_cnt=%0d expected=%0d",
             inst, e.tag, o_lk, o_er, o_rg, o_ec, o_ex);
    check({e.tag, ".locked"},    o_lk, e.lk);
    check({e.tag, ".err"},       o_er, e.er);
    check({e.tag, ".err_range"}, o_rg, e.rg);
    check({e.tag, ".err_cnt"},   o_ec, e.ec);
    check({e.tag, ".expected"},  o_ex, e.ex);
  endtask

  // Drive one cycle on one instance, push the expectation, then pop and
  // compare once the registered outputs have settled after the edge.
  task automatic step(input int inst, input bit v, input int d, input bit c,
                      input int e_lk, input int e_er, input int e_rg,
                      input int e_ec, input int e_ex, input string tag);
    exp_t e;
    cin[inst] = 5'(d);
    vld[inst] = v;
    clr[inst] = c;
    e = '{tag, e_lk, e_er, e_rg, e_ec, e_ex};
    sb.push_back(e);
    @(posedge CLK);
    #1;
    vld[inst] = 1'b0;
    clr[inst] = 1'b0;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      compare(inst, e);
    end
  endtask

  task automatic check_reset_state(input int inst, input string tag);
    exp_t e;
    e = '{tag, 0, 0, 0, 0, 0};
    compare(inst, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      cin[i] = '0;
      vld[i] = 1'b0;
      clr[i] = 1'b0;
    end
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_state(0, "A_reset");
    RST = 1'b1;
    @(negedge CLK);

    // ---- inst 0: forward M=17 STEP=3 ----
    step(0, 1,  0, 0, 0, 0, 0, 0,  3, "A_s0");
    step(0, 1,  3, 0, 0, 0, 0, 0,  6, "A_s3");
    step(0, 1,  6, 0, 0, 0, 0, 0,  9, "A_s6");
    step(0, 1,  9, 0, 0, 0, 0, 0, 12, "A_s9");
    step(0, 1, 12, 0, 1, 0, 0, 0, 15, "A_lock");
    step(0, 1, 15, 0, 1, 0, 0, 0,  1, "A_s15");
    step(0, 1,  1, 0, 1, 0, 0, 0,  4, "A_wrap");
    step(0, 1,  4, 0, 1, 0, 0, 0,  7, "A_exp7");
    step(0, 0, 11, 0, 1, 0, 0, 0,  7, "A_gap1");
    step(0, 0, 11, 0, 1, 0, 0, 0,  7, "A_gap2");
    step(0, 1,  7, 0, 1, 0, 0, 0, 10, "A_s7");
    step(0, 1, 20, 0, 0, 1, 1, 1, 10, "A_oor");
    step(0, 0, 11, 0, 0, 0, 0, 1, 10, "A_pulse");
    step(0, 1, 14, 0, 0, 0, 0, 1,  0, "A_idle14");
    step(0, 1,  0, 0, 0, 0, 0, 1,  3, "A_m1");
    step(0, 1,  3, 0, 0, 0, 0, 1,  6, "A_m2");
    step(0, 1,  6, 0, 0, 0, 0, 1,  9, "A_m3");
    step(0, 1,  9, 0, 1, 0, 0, 1, 12, "A_lock9");
    step(0, 1, 11, 0, 0, 1, 0, 2, 14, "A_err11");
    step(0, 0, 11, 0, 0, 0, 0, 2, 14, "A_pulse2");
    step(0, 1, 14, 0, 0, 0, 0, 2,  0, "A_re14");
    step(0, 1,  0, 0, 0, 0, 0, 2,  3, "A_re0");
    step(0, 1,  3, 0, 0, 0, 0, 2,  6, "A_re3");
    step(0, 1,  6, 0, 1, 0, 0, 2,  9, "A_relock");
    step(0, 1, 20, 1, 0, 1, 1, 1,  9, "A_clr_err");
    step(0, 0,  0, 1, 0, 0, 0, 0,  9, "A_clr");
    step(0, 1, 25, 0, 0, 0, 0, 0,  9, "A_idle_oor");
    step(0, 1,  5, 0, 0, 0, 0, 0,  8, "A_acq5");
    step(0, 1,  8, 0, 0, 0, 0, 0, 11, "A_acq8");
    step(0, 1, 30, 0, 0, 0, 0, 0, 11, "A_acq_oor");
    step(0, 1, 11, 0, 0, 0, 0, 0, 14, "A_n11");
    step(0, 1, 14, 0, 0, 0, 0, 0,  0, "A_n14");
    step(0, 1,  0, 0, 0, 0, 0, 0,  3, "A_n0");
    step(0, 1,  3, 0, 0, 0, 0, 0,  6, "A_nolock");
    step(0, 1,  6, 0, 1, 0, 0, 0,  9, "A_lock6");
    step(0, 1, 10, 0, 0, 1, 0, 1, 13, "A_err10");
    step(0, 1, 13, 0, 0, 0, 0, 1, 16, "A_r13");
    step(0, 1, 16, 0, 0, 0, 0, 1,  2, "A_r16");
    step(0, 1,  2, 0, 0, 0, 0, 1,  5, "A_r2");
    step(0, 1,  5, 0, 1, 0, 0, 1,  8, "A_r5lock");

    // Asynchronous reset while locked: outputs clear with no clock edge.
    RST = 1'b0;
    #1;
    check_reset_state(0, "A_async_rst");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // ACQ mismatch in range restarts the match count without any err.
    step(0, 1,  0, 0, 0, 0, 0, 0,  3, "A_p0");
    step(0, 1,  3, 0, 0, 0, 0, 0,  6, "A_p3");
    step(0, 1,  6, 0, 0, 0, 0, 0,  9, "A_p6");
    step(0, 1, 10, 0, 0, 0, 0, 0, 13, "A_acq_mis");
    step(0, 1, 13, 0, 0, 0, 0, 0, 16, "A_q13");
    step(0, 1, 16, 0, 0, 0, 0, 0,  2, "A_q16");
    step(0, 1,  2, 0, 0, 0, 0, 0,  5, "A_q2");
    step(0, 1,  5, 0, 1, 0, 0, 0,  8, "A_qlock");

    // ---- inst 1: reverse M=17 STEP=3 ----
    check_reset_state(1, "B_reset");
    step(1, 1,  0, 0, 0, 0, 0, 0, 14, "B_s0");
    step(1, 1, 14, 0, 0, 0, 0, 0, 11, "B_s14");
    step(1, 1, 11, 0, 0, 0, 0, 0,  8, "B_s11");
    step(1, 1,  8, 0, 0, 0, 0, 0,  5, "B_s8");
    step(1, 1,  5, 0, 1, 0, 0, 0,  2, "B_lock");
    step(1, 1,  2, 0, 1, 0, 0, 0, 16, "B_s2");
    step(1, 1, 16, 0, 1, 0, 0, 0, 13, "B_wrap");

    // ---- inst 2: reverse M=8 STEP=5 ----
    check_reset_state(2, "C_reset");
    step(2, 1, 0, 0, 0, 0, 0, 0, 3, "C_s0");
    step(2, 1, 3, 0, 0, 0, 0, 0, 6, "C_s3");
    step(2, 1, 6, 0, 0, 0, 0, 0, 1, "C_s6");
    step(2, 1, 1, 0, 0, 0, 0, 0, 4, "C_s1");
    step(2, 1, 4, 0, 1, 0, 0, 0, 7, "C_lock");
    step(2, 1, 7, 0, 1, 0, 0, 0, 2, "C_s7");
    step(2, 1, 2, 0, 1, 0, 0, 0, 5, "C_s2");
    step(2, 1, 5, 0, 1, 0, 0, 0, 0, "C_s5");
    step(2, 1, 0, 0, 1, 0, 0, 0, 3, "C_period");

    // ---- inst 3: LOCK_CNT=1, 2-bit saturating error counter ----
    check_reset_state(3, "D_reset");
    step(3, 1,  0, 0, 0, 0, 0, 0,  1, "D_s0");
    step(3, 1,  1, 0, 1, 0, 0, 0,  2, "D_lock");
    step(3, 1,  5, 0, 0, 1, 0, 1,  6, "D_err1");
    step(3, 1,  6, 0, 1, 0, 0, 1,  7, "D_relock1");
    step(3, 1,  0, 0, 0, 1, 0, 2,  1, "D_err2");
    step(3, 1,  1, 0, 1, 0, 0, 2,  2, "D_relock2");
    step(3, 1,  9, 0, 0, 1, 0, 3, 10, "D_err3");
    step(3, 1, 10, 0, 1, 0, 0, 3, 11, "D_relock3");
    step(3, 1,  0, 0, 0, 1, 0, 3,  1, "D_sat");

    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cntr_checker.md
Name: cntr_checker

Overview:
- Receive-side companion to the configurable modulo counter (CNTR).
- Samples a counter value stream and locks onto the expected sequence ((prev ± STEP) mod CNT_MODULE). After lock, flags every deviation.
- Used in-system to monitor counter-driven sequencers and in benches as a self-checking sink for CNTR instances.

Parameters:
- STEP, 1: counter increment per sample; any positive value, reduced internally to STEP_M = STEP % CNT_MODULE.
- CNT_MODULE, 16: counter modulus, must be >= 2; legal values 0..CNT_MODULE-1.
- REVERSE, 0: 0 = expect up-counting, 1 = expect down-counting.
- LOCK_CNT, 4: consecutive matching transitions required to lock, >= 1.
- ERR_W, 16: width of the error counter.
- Derived W = $clog2(CNT_MODULE): width of the counter value.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset (0 = reset).
- cnt_in  in  W  sampled counter value.
- cnt_vld  in  1  cnt_in is valid this cycle; no sample is taken otherwise.
- clr  in  1  synchronous clear of err_cnt only.
- locked  out  1  checker is locked to the sequence.
- err  out  1  one-cycle pulse: a mismatch was seen while locked.
- err_range  out  1  one-cycle pulse, asserted with err when the mismatching sample was >= CNT_MODULE.
- err_cnt  out  ERR_W  saturating count of err pulses.
- expected  out  W  next value the checker expects; valid when locked.

Behaviour:
- Reset (RST=0, async): state=IDLE, locked=0, err=0, err_range=0, err_cnt=0, expected=0, prev=0, match_cnt=0.
- Next-value function nxt(p):
  - Forward: p+STEP_M if < CNT_MODULE, else p+STEP_M-CNT_MODULE.
  - Reverse: p-STEP_M if p >= STEP_M, else p+CNT_MODULE-STEP_M.
  - Compute at W+1 bits; no overflow for any W.
- A sample is in range iff cnt_in < CNT_MODULE. An out-of-range sample never matches.
- FSM, evaluated only on cycles with cnt_vld=1. With cnt_vld=0, all state holds and err/err_range=0.
- IDLE:
  - In-range sample: prev<=cnt_in, match_cnt<=0, go ACQ.
  - Out-of-range sample: stay IDLE.
  - No err pulses.
- ACQ:
  - Sample == nxt(prev): match_cnt++, prev<=cnt_in. When match_cnt reaches LOCK_CNT, go LOCK.
  - Mismatch, in range: prev<=cnt_in, match_cnt<=0.
  - Mismatch, out of range: go IDLE.
  - No err pulses in ACQ.
- LOCK:
  - locked=1.
  - Match: prev<=cnt_in, stay.
  - Mismatch: err=1 next cycle, err_range=1 if out of range, err_cnt++ saturating at 2^ERR_W-1, locked drops next cycle.
  - After a mismatch, re-acquire exactly as in ACQ: in-range sample → ACQ with prev<=cnt_in and match_cnt=0; out-of-range sample → IDLE.
- Latency:
  - locked rises the cycle after the LOCK_CNT-th matching transition is sampled.
  - err pulses the cycle after the offending sample.
- expected = nxt(prev), registered, updated with prev.
- clr=1: err_cnt<=0. If clr coincides with a new error, err_cnt<=1; err still pulses.
- Wrap-around: a modulus crossing (e.g. 15→1 for M=17, STEP=3) is a normal match.
- Reset mid-operation returns to IDLE immediately regardless of state.

Test Plan:
- Fwd M=17, STEP=3, LOCK_CNT=4: feed 0,3,6,9,12 on consecutive cycles → locked=1 the cycle after 12. Continue 15,1,4 → no err; expected=7 after sample 4.
- Rev M=17, STEP=3: feed 0,14,11,8,5,2,16 → lock after 5; wrap 2→16 accepted, err_cnt=0.
- Rev M=8, STEP=5 (edge, W=3): feed 0,3,6,1,4,7,2,5,0 → lock after 4, no err through the full period.
- Locked fwd M=17, STEP=3 at value 9: inject 11 → err=1 one cycle, locked=0, err_cnt=1. Then 14,0,3,6 → re-lock.
- Locked, inject 20 on a 5-bit M=17 checker → err=1, err_range=1, state IDLE. Assert clr in the same cycle as the next error → err_cnt=1.
- cnt_vld gaps between samples hold state. Pull RST low while locked → locked=0, err_cnt=0 asynchronously, without waiting for a clock edge.
